flood_engine: RTL and testbench
===============================

# flood_engine

Board-state and flood-fill engine for Flood It, sitting between board generation and display. It accepts the generated board as a raster stream and holds up to 26×26 3-bit cells. On each colour selection it grows the player's region from cell (0,0) by iterative raster sweeps. It exposes a registered read port for the VGA stage, plus move count, busy and solved status for select/digit display.

## Interface
- MAX_SIZE, 26: largest board edge; sets storage and index widths.
- COLOR_W, 3: bits per cell colour.

- CLOCK  in  1  single clock for all state.
- RESET  in  1  synchronous, active-high.
- LOAD_START  in  1  pulse; latches final_SIZE and begins a board load, aborting anything in progress.
- final_SIZE  in  5  board edge N; clamped to 2..26 when latched.
- LOAD_VALID  in  1  LOAD_DATA holds the next cell in raster order (row-major from (0,0)).
- LOAD_DATA  in  3  cell colour.
- COLOR_SEL_SIG  in  1  pulse requesting a move.
- COLOR_SELECTED  in  3  colour for the move.
- RD_ROW, RD_COL  in  5 each  display read address.
- RD_DATA  out  3  registered cell colour.
- CHANGING_COLOR  out  1  busy; high in LOAD and SCAN.
- BOARD_VALID  out  1  board loaded and seeded.
- MOVE_DONE  out  1  one-cycle pulse on SCAN→READY.
- MOVES  out  8  counted moves, saturating.
- SOLVED  out  1  every cell is owned.

## Operation
- Storage per cell: colour[3] and owned[1]. Also held: cur_color[3], target[3], owned_cnt[10], scan row/column, changed flag.
- States: EMPTY, LOAD, SCAN, READY.
- **EMPTY** (after reset): no board. COLOR_SEL_SIG is ignored.
- **LOAD_START**, from any state, is checked first:
  - Latch N.
  - Clear all owned bits, MOVES, owned_cnt, BOARD_VALID and SOLVED.
  - Load index ← 0; go to LOAD.
- **LOAD**: each cycle with LOAD_VALID high, write LOAD_DATA at the load index and increment it. After N² accepted cells:
  - Set owned(0,0) and owned_cnt = 1.
  - cur_color = target = colour(0,0).
  - Go to SCAN. This seed scan does not count as a move.
  - LOAD_VALID is ignored outside LOAD.
- **READY**, on COLOR_SEL_SIG:
  - If COLOR_SELECTED ≠ cur_color and SOLVED = 0: MOVES ← MOVES+1 (saturating at 255), cur_color = target = COLOR_SELECTED, go to SCAN.
  - Otherwise the request is ignored: no count and no busy.
- **SCAN** visits one cell per cycle in raster order (r,c) = (0,0)..(N-1,N-1):
  - Owned cell: colour ← target.
  - Unowned cell with colour = target and at least one owned in-bounds 4-neighbour: owned ← 1, owned_cnt +1, changed ← 1.
  - Cells marked earlier in the same pass are visible to later cells.
- **End of pass**, at cell (N-1,N-1):
  - If changed was set during the pass (including on the last cell), clear changed and restart at (0,0).
  - Otherwise go to READY and pulse MOVE_DONE. The first entry to READY after a load also sets BOARD_VALID.
- SOLVED = (owned_cnt == N²), registered; it updates when READY is entered.
- Read port: RD_DATA ← colour(RD_ROW,RD_COL) one cycle after the address is presented.
  - Returns 0 if RD_ROW ≥ N or RD_COL ≥ N, or in EMPTY.
  - During SCAN it returns the current stored value. Mid-update tearing is accepted.
- COLOR_SEL_SIG during LOAD or SCAN is dropped, not queued.

## Timing
- Reset values: RD_DATA 0, CHANGING_COLOR 0, BOARD_VALID 0, MOVE_DONE 0, MOVES 0, SOLVED 0; state EMPTY.
- LOAD_START → CHANGING_COLOR high on the next cycle.
- Load takes N² LOAD_VALID cycles, then the seed scan.
- Each pass takes exactly N² cycles. A move takes k·N² cycles, where k ≥ 1 passes (the final pass makes no change).
- MOVE_DONE and the CHANGING_COLOR fall occur on the same edge. COLOR_SEL_SIG is honoured from the following cycle.
- COLOR_SEL_SIG → CHANGING_COLOR high next cycle; MOVES updates on that same edge.
- RESET mid-LOAD or mid-SCAN returns everything to reset values next cycle. Storage contents are don't-care.
- LOAD_START mid-SCAN takes priority over the scan. MOVE_DONE is not pulsed.

## Test plan
- Reset: assert RESET for 2 cycles → all outputs 0. COLOR_SEL_SIG afterwards → no effect.
- 2×2 board [0,1;1,1]: load, then wait → BOARD_VALID = 1, MOVES = 0, SOLVED = 0 after exactly 4 load cycles plus 4 scan cycles. Select colour 1 → MOVES = 1, SOLVED = 1, all RD_DATA reads = 1, MOVE_DONE after 8 cycles (2 passes).
- Ignored moves: select cur_color, then select after SOLVED → MOVES unchanged, CHANGING_COLOR stays 0.
- Backward propagation: 4×4 board with (0,0)=0 and a colour-2 serpentine that climbs from row 3 to row 0 at column 3. Select 2 → whole path owned, pass count > 2, final pass with no change, owned_cnt exact.
- Abort: LOAD_START during SCAN → no MOVE_DONE, MOVES = 0, new board loads and seeds correctly. RD outside N → 0.
- Saturation: 2×2 board [0,1;2,1], alternately select colours 3 and 4 for 260 moves → MOVES sticks at 255, SOLVED stays 0.

Source files
------------

// File: rtl/flood_engine.sv
// Flood It board store and flood-fill engine: raster board load, iterative
// raster-sweep region growth from (0,0), registered display read port.
module flood_engine #(
  parameter int MAX_SIZE = 26,
  parameter int COLOR_W  = 3
) (
  input  logic               CLOCK,
  input  logic               RESET,
  input  logic               LOAD_START,
  input  logic [4:0]         final_SIZE,
  input  logic               LOAD_VALID,
  input  logic [COLOR_W-1:0] LOAD_DATA,
  input  logic               COLOR_SEL_SIG,
  input  logic [COLOR_W-1:0] COLOR_SELECTED,
  input  logic [4:0]         RD_ROW,
  input  logic [4:0]         RD_COL,
  output logic [COLOR_W-1:0] RD_DATA,
  output logic               CHANGING_COLOR,
  output logic               BOARD_VALID,
  output logic               MOVE_DONE,
  output logic [7:0]         MOVES,
  output logic               SOLVED
);

  // state | meaning
  // EMPTY | no board since reset; moves ignored, reads return 0
  // LOAD  | accepting raster cells until N*N have arrived
  // SCAN  | one cell per cycle, passes repeat until one makes no change
  // READY | board stable, waiting for a colour selection
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] SCAN  = 2'd2;
  localparam logic [1:0] READY = 2'd3;

  localparam int IDX_W = 5;
  localparam int CNT_W = $clog2(MAX_SIZE * MAX_SIZE + 1);
  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(MAX_SIZE);
  localparam logic [IDX_W-1:0] MIN_IDX = IDX_W'(2);

  logic [1:0]         state;
  logic [IDX_W-1:0]   n_size;
  logic [IDX_W-1:0]   n_last;
  logic [CNT_W-1:0]   n_sq;
  logic [IDX_W-1:0]   row, col;
  logic [COLOR_W-1:0] cur_color, target;
  logic [CNT_W-1:0]   owned_cnt;
  logic               changed;

  logic [COLOR_W-1:0] cell_color [MAX_SIZE][MAX_SIZE];
  logic               cell_owned [MAX_SIZE][MAX_SIZE];

  logic [IDX_W-1:0]   size_clamped;
  logic [IDX_W-1:0]   r_up, r_dn, c_lt, c_rt;
  logic               nbr_owned, grow, last_cell;
  logic               rd_in;
  logic [IDX_W-1:0]   rd_r, rd_c;

  assign n_last         = n_size - IDX_W'(1);
  assign n_sq           = CNT_W'(n_size) * CNT_W'(n_size);
  assign last_cell      = (row == n_last) && (col == n_last);
  assign CHANGING_COLOR = (state == LOAD) || (state == SCAN);

  always_comb begin
    size_clamped = final_SIZE;
    if (final_SIZE < MIN_IDX)      size_clamped = MIN_IDX;
    else if (final_SIZE > MAX_IDX) size_clamped = MAX_IDX;
  end

  // Neighbour indices are clamped so the array is never indexed out of range;
  // the bounds terms below decide whether the neighbour really exists.
  always_comb begin
    r_up = (row == '0) ? row : row - IDX_W'(1);
    r_dn = (row == MAX_IDX - IDX_W'(1)) ? row : row + IDX_W'(1);
    c_lt = (col == '0) ? col : col - IDX_W'(1);
    c_rt = (col == MAX_IDX - IDX_W'(1)) ? col : col + IDX_W'(1);
    nbr_owned = ((row != '0)    && cell_owned[r_up][col]) ||
                ((row != n_last) && cell_owned[r_dn][col]) ||
                ((col != '0)    && cell_owned[row][c_lt]) ||
                ((col != n_last) && cell_owned[row][c_rt]);
    grow = (state == SCAN) && !cell_owned[row][col] &&
           (cell_color[row][col] == target) && nbr_owned;
  end

  always_comb begin
    rd_in = (state != EMPTY) && (RD_ROW < n_size) && (RD_COL < n_size);
    rd_r  = rd_in ? RD_ROW : '0;
    rd_c  = rd_in ? RD_COL : '0;
  end

  // Board storage carries no reset; a load rewrites every cell it uses.
  always_ff @(posedge CLOCK) begin
    if (LOAD_START) begin
      for (int r = 0; r < MAX_SIZE; r++)
        for (int c = 0; c < MAX_SIZE; c++)
          cell_owned[r][c] <= 1'b0;
    end else begin
      case (state)
        LOAD: if (LOAD_VALID) begin
          cell_color[row][col] <= LOAD_DATA;
          if (last_cell) cell_owned[0][0] <= 1'b1;
        end
        SCAN: begin
          if (cell_owned[row][col]) cell_color[row][col] <= target;
          else if (grow)            cell_owned[row][col] <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state       <= EMPTY;
      n_size      <= MIN_IDX;
      row         <= '0;
      col         <= '0;
      cur_color   <= '0;
      target      <= '0;
      owned_cnt   <= '0;
      changed     <= 1'b0;
      RD_DATA     <= '0;
      BOARD_VALID <= 1'b0;
      MOVE_DONE   <= 1'b0;
      MOVES       <= '0;
      SOLVED      <= 1'b0;
    end else begin
      MOVE_DONE <= 1'b0;
      RD_DATA   <= rd_in ? cell_color[rd_r][rd_c] : '0;
      if (LOAD_START) begin
        n_size      <= size_clamped;
        MOVES       <= '0;
        owned_cnt   <= '0;
        BOARD_VALID <= 1'b0;
        SOLVED      <= 1'b0;
        changed     <= 1'b0;
        row         <= '0;
        col         <= '0;
        state       <= LOAD;
      end else begin
        case (state)
          LOAD: if (LOAD_VALID) begin
            if (last_cell) begin
              owned_cnt <= CNT_W'(1);
              cur_color <= cell_color[0][0];
              target    <= cell_color[0][0];
              row       <= '0;
              col       <= '0;
              changed   <= 1'b0;
              state     <= SCAN;
            end else if (col == n_last) begin
              col <= '0;
              row <= row + IDX_W'(1);
            end else begin
              col <= col + IDX_W'(1);
            end
          end
          READY: if (COLOR_SEL_SIG && (COLOR_SELECTED != cur_color) && !SOLVED) begin
            if (MOVES != 8'hFF) MOVES <= MOVES + 8'd1;
            cur_color <= COLOR_SELECTED;
            target    <= COLOR_SELECTED;
            row       <= '0;
            col       <= '0;
            changed   <= 1'b0;
            state     <= SCAN;
          end
          SCAN: begin
            if (grow) owned_cnt <= owned_cnt + CNT_W'(1);
            if (last_cell) begin
              row <= '0;
              col <= '0;
              if (changed || grow) begin
                changed <= 1'b0;
              end else begin
                state       <= READY;
                MOVE_DONE   <= 1'b1;
                BOARD_VALID <= 1'b1;
                SOLVED      <= (owned_cnt == n_sq);
              end
            end else begin
              if (grow) changed <= 1'b1;
              if (col == n_last) begin
                col <= '0;
                row <= row + IDX_W'(1);
              end else begin
                col <= col + IDX_W'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_flood_engine.sv
// Directed bench for flood_engine: load, moves, multi-pass growth, abort,
// ignored requests, saturation and reset.
module tb_flood_engine;
  logic       CLOCK = 1'b0;
  logic       RESET, LOAD_START, LOAD_VALID, COLOR_SEL_SIG;
  logic [4:0] final_SIZE, RD_ROW, RD_COL;
  logic [2:0] LOAD_DATA, COLOR_SELECTED, RD_DATA;
  logic       CHANGING_COLOR, BOARD_VALID, MOVE_DONE, SOLVED;
  logic [7:0] MOVES;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int cyc;
  int pulse_mark;
  logic [2:0] brd [0:15];

  flood_engine dut (
    .CLOCK(CLOCK), .RESET(RESET), .LOAD_START(LOAD_START), .final_SIZE(final_SIZE),
    .LOAD_VALID(LOAD_VALID), .LOAD_DATA(LOAD_DATA), .COLOR_SEL_SIG(COLOR_SEL_SIG),
    .COLOR_SELECTED(COLOR_SELECTED), .RD_ROW(RD_ROW), .RD_COL(RD_COL),
    .RD_DATA(RD_DATA), .CHANGING_COLOR(CHANGING_COLOR), .BOARD_VALID(BOARD_VALID),
    .MOVE_DONE(MOVE_DONE), .MOVES(MOVES), .SOLVED(SOLVED)
  );

  always #5 CLOCK = ~CLOCK;
  always @(posedge CLOCK) if (MOVE_DONE === 1'b1) pulses++;

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // which = 0 waits for MOVE_DONE, 1 for BOARD_VALID; -1 on timeout
  task automatic wait_sig(input int which, output int n);
    n = -1;
    for (int i = 1; i <= 2000; i++) begin
      tick();
      if ((which == 0 && MOVE_DONE === 1'b1) || (which == 1 && BOARD_VALID === 1'b1)) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic load_board(input logic [4:0] size_in, input int cells);
    final_SIZE = size_in;
    LOAD_START = 1'b1;
    tick();
    LOAD_START = 1'b0;
    LOAD_VALID = 1'b1;
    for (int i = 0; i < cells; i++) begin
      LOAD_DATA = brd[i];
      tick();
    end
    LOAD_VALID = 1'b0;
  endtask

  task automatic select(input logic [2:0] c);
    COLOR_SELECTED = c;
    COLOR_SEL_SIG  = 1'b1;
    tick();
    COLOR_SEL_SIG  = 1'b0;
  endtask

  task automatic rd(input int r, input int c, input int exp, input string tag);
    RD_ROW = 5'(r);
    RD_COL = 5'(c);
    tick();
    chk(tag, int'(RD_DATA), exp);
  endtask

  initial begin
    RESET = 1'b1; LOAD_START = 1'b0; LOAD_VALID = 1'b0; COLOR_SEL_SIG = 1'b0;
    final_SIZE = 5'd2; LOAD_DATA = '0; COLOR_SELECTED = '0; RD_ROW = '0; RD_COL = '0;
    tick(); tick();
    RESET = 1'b0;
    chk("rst_rd_data", int'(RD_DATA), 0);
    chk("rst_busy", int'(CHANGING_COLOR), 0);
    chk("rst_board_valid", int'(BOARD_VALID), 0);
    chk("rst_move_done", int'(MOVE_DONE), 0);
    chk("rst_moves", int'(MOVES), 0);
    chk("rst_solved", int'(SOLVED), 0);
    select(3'd2);
    chk("empty_sel_busy", int'(CHANGING_COLOR), 0);
    chk("empty_sel_moves", int'(MOVES), 0);

    // 2x2 [0,1;1,1]
    brd[0] = 3'd0; brd[1] = 3'd1; brd[2] = 3'd1; brd[3] = 3'd1;
    load_board(5'd2, 4);
    chk("2x2_busy_load", int'(CHANGING_COLOR), 1);
    wait_sig(1, cyc);
    chk("2x2_seed_cycles", cyc, 4);
    chk("2x2_seed_moves", int'(MOVES), 0);
    chk("2x2_seed_solved", int'(SOLVED), 0);
    chk("2x2_seed_busy", int'(CHANGING_COLOR), 0);
    rd(0, 0, 0, "2x2_rd00_pre");
    rd(0, 1, 1, "2x2_rd01_pre");
    select(3'd1);
    chk("2x2_move_busy", int'(CHANGING_COLOR), 1);
    chk("2x2_move_moves", int'(MOVES), 1);
    wait_sig(0, cyc);
    chk("2x2_move_cycles", cyc, 8);
    chk("2x2_move_busy_fall", int'(CHANGING_COLOR), 0);
    chk("2x2_solved", int'(SOLVED), 1);
    rd(0, 0, 1, "2x2_rd00");
    rd(0, 1, 1, "2x2_rd01");
    rd(1, 0, 1, "2x2_rd10");
    rd(1, 1, 1, "2x2_rd11");
    select(3'd2);
    chk("solved_sel_busy", int'(CHANGING_COLOR), 0);
    chk("solved_sel_moves", int'(MOVES), 1);

    // 4x4 serpentine climbing column 3
    brd = '{3'd0, 3'd2, 3'd1, 3'd2,
            3'd1, 3'd2, 3'd1, 3'd2,
            3'd1, 3'd2, 3'd1, 3'd2,
            3'd1, 3'd2, 3'd2, 3'd2};
    load_board(5'd4, 16);
    wait_sig(1, cyc);
    chk("4x4_seed_cycles", cyc, 16);
    select(3'd0);
    chk("same_sel_busy", int'(CHANGING_COLOR), 0);
    chk("same_sel_moves", int'(MOVES), 0);
    select(3'd2);
    wait_sig(0, cyc);
    chk("4x4_move_cycles_5pass", cyc, 80);
    chk("4x4_owned_cnt", int'(dut.owned_cnt), 10);
    chk("4x4_moves", int'(MOVES), 1);
    chk("4x4_not_solved", int'(SOLVED), 0);
    rd(0, 0, 2, "4x4_rd00");
    rd(0, 2, 1, "4x4_rd02");
    rd(3, 0, 1, "4x4_rd30");
    select(3'd1);
    wait_sig(0, cyc);
    chk("4x4_fill_cycles", cyc, 32);
    chk("4x4_fill_solved", int'(SOLVED), 1);
    chk("4x4_fill_moves", int'(MOVES), 2);
    rd(3, 3, 1, "4x4_rd33");

    // Abort a move with a new 3x3 load
    brd = '{3'd0, 3'd2, 3'd1, 3'd2,
            3'd1, 3'd2, 3'd1, 3'd2,
            3'd1, 3'd2, 3'd1, 3'd2,
            3'd1, 3'd2, 3'd2, 3'd2};
    load_board(5'd4, 16);
    wait_sig(1, cyc);
    select(3'd2);
    repeat (10) tick();
    pulse_mark = pulses;
    for (int i = 0; i < 9; i++) brd[i] = 3'd5;
    load_board(5'd3, 9);
    chk("abort_moves", int'(MOVES), 0);
    chk("abort_no_pulse", pulses, pulse_mark);
    chk("abort_board_valid", int'(BOARD_VALID), 0);
    wait_sig(1, cyc);
    chk("3x3_seed_cycles", cyc, 18);
    chk("3x3_seed_solved", int'(SOLVED), 1);
    rd(2, 2, 5, "3x3_rd22");
    rd(3, 0, 0, "3x3_rd_row_out");
    rd(0, 3, 0, "3x3_rd_col_out");

    // Saturation on a 2x2 that can never be solved; size 0 clamps to 2
    brd[0] = 3'd0; brd[1] = 3'd1; brd[2] = 3'd2; brd[3] = 3'd1;
    load_board(5'd0, 4);
    wait_sig(1, cyc);
    chk("clamp_seed_cycles", cyc, 4);
    for (int m = 1; m <= 260; m++) begin
      select((m % 2 == 1) ? 3'd3 : 3'd4);
      wait_sig(0, cyc);
      if (m == 255) chk("sat_moves_255", int'(MOVES), 255);
      if (m == 1)   chk("sat_pass_cycles", cyc, 4);
    end
    chk("sat_moves_final", int'(MOVES), 255);
    chk("sat_not_solved", int'(SOLVED), 0);

    // Reset during a scan
    select(3'd3);
    chk("pre_reset_busy", int'(CHANGING_COLOR), 1);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("midscan_rst_busy", int'(CHANGING_COLOR), 0);
    chk("midscan_rst_moves", int'(MOVES), 0);
    chk("midscan_rst_valid", int'(BOARD_VALID), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
